mips_multicycle_core: RTL

//  Multicycle MIPS-subset core. Replaces the bench-side fetch/decode/execute task with synthesizable control.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/mips_if.sv | 14 +
 rtl/mips_regfile.sv | 24 ++
 rtl/mips_multicycle_core.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcodes, FSM state encoding and ALU helpers for the multicycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic {ALU_ADD, ALU_SUB} alu_op_t;

  // y is the operand as actually fed to the adder (already inverted for SUB)
  function automatic logic add_ovf(input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] r);
    return (x[31] == y[31]) && (r[31] != x[31]);
  endfunction

endpackage

// File: rtl/mips_if.sv
// Shared instruction/data memory handshake between the core (master) and memory (slave).
interface mips_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file: two async read ports, async debug read, one sync write; $0 reads as 0.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  dbg_ra,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] dbg_rd,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0][31:0] regs;

  always_ff @(posedge clk or posedge rst)
    if (rst)                     regs     <= '0;
    else if (we && wa != 5'd0)   regs[wa] <= wd;

  assign rd1    = (ra1    == 5'd0) ? '0 : regs[ra1];
  assign rd2    = (ra2    == 5'd0) ? '0 : regs[ra2];
  assign dbg_rd = (dbg_ra == 5'd0) ? '0 : regs[dbg_ra];
endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset (ADD/SUB/ADDI/LW/SW/BEQ/SYSCALL) over one shared memory handshake.
// Define MIPS_OVERFLOW_TRAP_EN to halt with trap on signed overflow of ADD/SUB/ADDI.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          MEM_AW   = 10,
  parameter int          WAIT_MAX = 0
) (
  input  logic        clk,
  input  logic        reset,
  mips_if.master      bus,
  output logic        halted,
  output logic        illegal,
  output logic        trap,
  output logic        retire,
  output logic [31:0] pc_o,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);
`ifdef MIPS_OVERFLOW_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [31:0] AMASK = (MEM_AW >= 32) ? 32'hFFFF_FFFC
                                 : (((32'h1 << MEM_AW) - 32'h1) & 32'hFFFF_FFFC);

  state_t      state, state_n;
  logic [31:0] pc, ir, a, b, imm, aluout, mdr, wcnt;
  logic        ill_q, trap_q;
  logic        ir_ld, dec_ld, alu_ld, mdr_ld, br_tk, rf_we, ret_c;
  logic        set_ill, set_trap, req_c, we_c, tmo;
  logic [31:0] addr_c, rf_a, rf_b;

  wire [5:0] op = ir[31:26];
  wire [5:0] fn = ir[5:0];
  wire is_add  = (op == OP_RTYPE) && (fn == FN_ADD);
  wire is_sub  = (op == OP_RTYPE) && (fn == FN_SUB);
  wire is_sys  = (op == OP_RTYPE) && (fn == FN_SYSCALL);
  wire is_addi = (op == OP_ADDI);
  wire is_lw   = (op == OP_LW);
  wire is_sw   = (op == OP_SW);
  wire is_beq  = (op == OP_BEQ);
  wire legal   = is_add | is_sub | is_addi | is_lw | is_sw | is_beq;

  // ALU: SUB is A + ~B + 1 so one adder and one overflow rule cover all ops
  alu_op_t     aop;
  logic [31:0] alu_y, alu_res;
  logic        ovf_trap;
  always_comb begin
    aop      = is_sub ? ALU_SUB : ALU_ADD;
    alu_y    = (is_add || is_sub) ? b : imm;
    if (aop == ALU_SUB) alu_y = ~alu_y;
    alu_res  = a + alu_y + {31'b0, aop == ALU_SUB};
    ovf_trap = TRAP_EN && (is_add || is_sub || is_addi) && add_ovf(a, alu_y, alu_res);
  end

  assign tmo = (WAIT_MAX > 0) && (wcnt == 32'(WAIT_MAX - 1));

  mips_regfile u_rf (
    .clk(clk), .rst(reset),
    .ra1(ir[25:21]), .ra2(ir[20:16]), .dbg_ra(dbg_raddr),
    .rd1(rf_a), .rd2(rf_b), .dbg_rd(dbg_rdata),
    .we(rf_we), .wa((is_lw || is_addi) ? ir[20:16] : ir[15:11]),
    .wd(is_lw ? mdr : aluout)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else       state <= state_n;

  always_comb begin
    state_n  = state;
    ir_ld    = 1'b0; dec_ld = 1'b0; alu_ld = 1'b0; mdr_ld = 1'b0;
    br_tk    = 1'b0; rf_we  = 1'b0; ret_c  = 1'b0;
    set_ill  = 1'b0; set_trap = 1'b0;
    req_c    = 1'b0; we_c   = 1'b0;
    addr_c   = pc & AMASK;
    unique case (state)
      FETCH: begin
        req_c = 1'b1;
        if (bus.mem_ready) begin ir_ld = 1'b1; state_n = DECODE; end
        else if (tmo)      begin set_trap = 1'b1; state_n = HALT; end
      end
      DECODE: begin
        dec_ld = 1'b1;
        if (is_sys)      begin ret_c = 1'b1; state_n = HALT; end
        else if (!legal) begin set_ill = 1'b1; state_n = HALT; end
        else             state_n = EXEC;
      end
      EXEC: begin
        alu_ld = 1'b1;
        if (is_beq)               begin br_tk = (a == b); ret_c = 1'b1; state_n = FETCH; end
        else if (ovf_trap)        begin set_trap = 1'b1; state_n = HALT; end
        else if (is_lw || is_sw)  state_n = MEM;
        else                      state_n = WB;
      end
      MEM: begin
        req_c  = 1'b1;
        we_c   = is_sw;
        addr_c = aluout & AMASK;
        if (bus.mem_ready) begin
          if (is_sw) begin ret_c = 1'b1; state_n = FETCH; end
          else       begin mdr_ld = 1'b1; state_n = WB; end
        end else if (tmo) begin set_trap = 1'b1; state_n = HALT; end
      end
      WB: begin rf_we = 1'b1; ret_c = 1'b1; state_n = FETCH; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= RESET_PC; ir <= '0; a <= '0; b <= '0; imm <= '0;
      aluout <= '0; mdr <= '0; wcnt <= '0; ill_q <= 1'b0; trap_q <= 1'b0;
    end else begin
      wcnt <= (req_c && !bus.mem_ready) ? wcnt + 32'd1 : '0;
      if (ir_ld)      begin ir <= bus.mem_rdata; pc <= pc + 32'd4; end
      else if (br_tk) pc <= pc + (imm << 2);
      if (dec_ld) begin a <= rf_a; b <= rf_b; imm <= {{16{ir[15]}}, ir[15:0]}; end
      if (alu_ld)   aluout <= alu_res;
      if (mdr_ld)   mdr    <= bus.mem_rdata;
      if (set_ill)  ill_q  <= 1'b1;
      if (set_trap) trap_q <= 1'b1;
    end

  // Reset must drop the request combinationally, before any clock edge
  assign bus.mem_req   = req_c & ~reset;
  assign bus.mem_we    = we_c & ~reset;
  assign bus.mem_addr  = reset ? '0 : addr_c;
  assign bus.mem_wdata = (we_c && !reset) ? b : '0;
  assign halted  = (state == HALT);
  assign illegal = ill_q;
  assign trap    = trap_q;
  assign retire  = ret_c;
  assign pc_o    = pc;
endmodule
